// File: rtl/dpmemwf_port_arbiter_if.sv
// Requester command/response bundle plus the single RAM port driven by the arbiter.
// The master side holds the requesters and the RAM, the slave side is the arbiter.
interface dpmemwf_port_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 10,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_we;
    logic [NREQ*DEPTH-1:0] req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  mem_en;
    logic                  mem_we;
    logic [DEPTH-1:0]      mem_addr;
    logic [WIDTH-1:0]      mem_di;
    logic [WIDTH-1:0]      mem_do;

    modport master (
        output req_valid, req_we, req_addr, req_data, mem_do,
        input  req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_di
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_data, mem_do,
        output req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_di
    );
endinterface

// File: rtl/dpmemwf_port_arbiter.sv
// Round-robin arbiter sharing one dpmemwf RAM port among NREQ requesters; read
// responses are routed back to their requester after the RAM read latency.
module dpmemwf_port_arbiter #(
    parameter int NREQ   = 4,
    parameter int DEPTH  = 10,
    parameter int WIDTH  = 32,
    parameter int OUTREG = 0
) (
    input logic                   clk,
    input logic                   srst,
    dpmemwf_port_arbiter_if.slave bus
);
    localparam int LAT = 1 + OUTREG;
    localparam int IW  = $clog2(NREQ);

    logic [IW-1:0]           ptr_q, ptr_d;
    logic                    gnt_vld;
    logic [IW-1:0]           gnt_id;
    logic [LAT-1:0]          vld_pipe_q, vld_pipe_d;
    logic [LAT-1:0][IW-1:0]  id_pipe_q, id_pipe_d;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        // walk the search order backwards so the requester nearest ptr wins
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(ptr_q) + k) % NREQ]) begin
                gnt_vld = 1'b1;
                gnt_id  = IW'((int'(ptr_q) + k) % NREQ);
            end
        end
        if (srst) gnt_vld = 1'b0;
    end

    always_comb begin
        bus.req_ready = '0;
        if (gnt_vld) bus.req_ready[gnt_id] = 1'b1;
        bus.mem_en   = gnt_vld;
        bus.mem_we   = gnt_vld & bus.req_we[gnt_id];
        bus.mem_addr = bus.req_addr[int'(gnt_id)*DEPTH +: DEPTH];
        bus.mem_di   = bus.req_data[int'(gnt_id)*WIDTH +: WIDTH];
    end

    always_comb begin
        ptr_d      = ptr_q;
        vld_pipe_d = vld_pipe_q;
        id_pipe_d  = id_pipe_q;
        if (gnt_vld) ptr_d = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IW'(1);
        for (int i = LAT - 1; i > 0; i--) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            id_pipe_d[i]  = id_pipe_q[i-1];
        end
        // writes still occupy a slot so the pipe advances uniformly
        vld_pipe_d[0] = gnt_vld & ~bus.req_we[gnt_id];
        id_pipe_d[0]  = gnt_id;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_q      <= '0;
            vld_pipe_q <= '0;
            id_pipe_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            vld_pipe_q <= vld_pipe_d;
            id_pipe_q  <= id_pipe_d;
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (vld_pipe_q[LAT-1] && !srst) bus.rsp_valid[id_pipe_q[LAT-1]] = 1'b1;
        bus.rsp_data = bus.mem_do;
    end
endmodule

// File: tb/tb_dpmemwf_port_arbiter.sv
// Bench for dpmemwf_port_arbiter: behavioural write-first dual-port RAM, a
// queue/array reference model, directed scenarios and a randomized phase.
module tb_dpmemwf_port_arbiter;
    localparam int NREQ   = 4;
    localparam int DEPTH  = 10;
    localparam int WIDTH  = 32;
    localparam int OUTREG = 1;
    localparam int LAT    = 1 + OUTREG;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    dpmemwf_port_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus();

    dpmemwf_port_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH), .OUTREG(OUTREG)) dut (
        .clk (clk),
        .srst(srst),
        .bus (bus.slave)
    );

    // write-first RAM; port A from the arbiter, port B driven directly here
    logic [WIDTH-1:0] ram [0:(1<<DEPTH)-1];
    logic [WIDTH-1:0] a_q, a_q2;
    logic             ram_clr, pb_en, pb_we;
    logic [DEPTH-1:0] pb_addr;
    logic [WIDTH-1:0] pb_di;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < (1 << DEPTH); i++) ram[i] <= '0;
        end else begin
            if (bus.mem_en) begin
                if (bus.mem_we) begin
                    ram[bus.mem_addr] <= bus.mem_di;
                    a_q <= bus.mem_di;
                end else begin
                    a_q <= ram[bus.mem_addr];
                end
            end
            if (pb_en && pb_we) ram[pb_addr] <= pb_di;
        end
        a_q2 <= a_q;
    end
    assign bus.mem_do = (OUTREG != 0) ? a_q2 : a_q;

    typedef struct { int due; int id; logic [WIDTH-1:0] data; } rsp_t;
    rsp_t             rq[$];
    logic [WIDTH-1:0] shadow [int];
    int               m_ptr = 0;
    int               cyc = 0;
    int               n_chk = 0;
    int               n_err = 0;
    int               act_g, last_eg;
    logic [NREQ-1:0]  s_rv;
    logic [WIDTH-1:0] s_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] rd(input int a);
        return shadow.exists(a) ? shadow[a] : '0;
    endfunction

    task automatic set_req(input int i, input logic v, input logic we, input int addr,
                           input logic [WIDTH-1:0] d);
        bus.req_valid[i]                 = v;
        bus.req_we[i]                    = we;
        bus.req_addr[i*DEPTH +: DEPTH]   = DEPTH'(addr);
        bus.req_data[i*WIDTH +: WIDTH]   = d;
    endtask

    task automatic clr_all();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 0, '0);
    endtask

    // one clock: check outputs at the falling edge, advance the model at the rising edge
    task automatic tick();
        int eg, p, a;
        logic [NREQ-1:0]  erdy, erv;
        logic [WIDTH-1:0] erd;
        @(negedge clk);
        eg = -1;
        if (!srst) begin
            for (int k = 0; k < NREQ; k++) begin
                p = (m_ptr + k) % NREQ;
                if (eg < 0 && bus.req_valid[p]) eg = p;
            end
        end
        erdy = '0;
        if (eg >= 0) erdy[eg] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(erdy));
        chk("mem_en", 64'(bus.mem_en), 64'(eg >= 0));
        if (eg >= 0) begin
            chk("mem_we", 64'(bus.mem_we), 64'(bus.req_we[eg]));
            chk("mem_addr", 64'(bus.mem_addr), 64'(bus.req_addr[eg*DEPTH +: DEPTH]));
            chk("mem_di", 64'(bus.mem_di), 64'(bus.req_data[eg*WIDTH +: WIDTH]));
        end
        erv = '0;
        erd = '0;
        if (!srst && rq.size() > 0 && rq[0].due == cyc) begin
            erv[rq[0].id] = 1'b1;
            erd = rq[0].data;
        end
        while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(erv));
        if (erv != '0) chk("rsp_data", 64'(bus.rsp_data), 64'(erd));
        s_rv  = bus.rsp_valid;
        s_rd  = bus.rsp_data;
        act_g = -1;
        for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) act_g = k;
        last_eg = eg;
        @(posedge clk);
        if (srst) begin
            m_ptr = 0;
            rq.delete();
        end else if (eg >= 0) begin
            m_ptr = (eg + 1) % NREQ;
            a = int'(bus.req_addr[eg*DEPTH +: DEPTH]);
            if (bus.req_we[eg]) shadow[a] = bus.req_data[eg*WIDTH +: WIDTH];
            else rq.push_back('{cyc + LAT, eg, rd(a)});
        end
        if (pb_en && pb_we) shadow[int'(pb_addr)] = pb_di;
        cyc++;
        #1;
    endtask

    initial begin
        srst = 1'b1; ram_clr = 1'b1;
        pb_en = 1'b0; pb_we = 1'b0; pb_addr = '0; pb_di = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, i, '0);
        repeat (3) tick();
        chk("rst_rsp_valid", 64'(s_rv), 64'(0));
        ram_clr = 1'b0;

        // fairness: all valid reads from reset
        srst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_order", 64'(act_g), 64'(k % NREQ));
        end
        clr_all();
        repeat (3) tick();

        // write then read from requester 1
        set_req(1, 1'b1, 1'b1, 1, 32'h11223344);
        tick();
        set_req(1, 1'b1, 1'b0, 1, '0);
        tick();
        clr_all();
        tick();
        tick();
        chk("wr_rd_rsp_valid", 64'(s_rv), 64'(4'b0010));
        chk("wr_rd_rsp_data", 64'(s_rd), 64'(32'h11223344));

        // skip and wrap: bring ptr to 1, then only req3 and req0 valid
        set_req(0, 1'b1, 1'b0, 5, '0);
        tick();
        set_req(0, 1'b1, 1'b0, 7, '0);
        set_req(3, 1'b1, 1'b0, 6, '0);
        tick(); chk("skip_g0", 64'(act_g), 64'(3));
        tick(); chk("skip_g1", 64'(act_g), 64'(0));
        tick(); chk("skip_g2", 64'(act_g), 64'(3));
        clr_all();
        repeat (3) tick();

        // port B write, then port A read of the same address
        pb_en = 1'b1; pb_we = 1'b1; pb_addr = DEPTH'(2); pb_di = 32'hCAFEDECA;
        tick();
        pb_en = 1'b0; pb_we = 1'b0;
        set_req(2, 1'b1, 1'b0, 2, '0);
        tick();
        clr_all();
        tick();
        tick();
        chk("pb_rsp_valid", 64'(s_rv), 64'(4'b0100));
        chk("pb_rsp_data", 64'(s_rd), 64'(32'hCAFEDECA));

        // reset while a read is in flight
        set_req(0, 1'b1, 1'b0, 3, '0);
        tick();
        clr_all();
        srst = 1'b1;
        tick(); chk("midrst_rv1", 64'(s_rv), 64'(0));
        srst = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("midrst_rv", 64'(s_rv), 64'(0));
        end
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 8 + i, '0);
        tick(); chk("midrst_ptr", 64'(act_g), 64'(0));
        clr_all();
        repeat (3) tick();

        // randomized traffic honouring the hold rule
        for (int c = 0; c < 600; c++) begin
            srst = ($urandom_range(0, 99) < 2);
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] || last_eg == i)
                    set_req(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, 15)), $urandom);
            end
            tick();
        end
        srst = 1'b0;
        clr_all();
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
